inject_arbiter: RTL and testbench

INJECT_ARBITER -- requirements
Module: inject_arbiter

---
 rtl/inject_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_inject_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inject_arbiter.sv
// Wormhole injection arbiter: merges NUM_REQ requesters onto one router local port.
// Define INJECT_ARB_STARVE_EN to add per-requester starvation counters that promote waiting low-priority sources.
module inject_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned FLIT_W       = 64,
  parameter int unsigned STARVE_LIMIT = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         src_valid,
  input  logic [NUM_REQ*FLIT_W-1:0]  src_flit,
  input  logic [NUM_REQ-1:0]         src_last,
  input  logic [NUM_REQ-1:0]         src_hipri,
  output logic [NUM_REQ-1:0]         src_ready,
  output logic                       req_out,
  output logic [FLIT_W-1:0]          flit_out,
  input  logic                       ack_in,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       busy
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    LOCK
  } state_t;

  state_t             state_q, state_d;
  logic               req_q, req_d;
  logic [FLIT_W-1:0]  flit_q, flit_d;
  logic               last_q, last_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;

  logic               load;
  logic               release_pkt;
  logic               owner_only;
  logic [IDX_W-1:0]   arb_ptr;
  logic [IDX_W-1:0]   hi_pick;
  logic [IDX_W-1:0]   any_pick;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant;
  logic [NUM_REQ-1:0] grant_vec;
  logic [NUM_REQ-1:0] promoted;
  logic [NUM_REQ-1:0] hi_cand;

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                input int unsigned      off);
    int unsigned sum;
    sum = (32'(base) + off) % NUM_REQ;
    return IDX_W'(sum);
  endfunction

`ifdef INJECT_ARB_STARVE_EN
  logic [NUM_REQ-1:0][7:0] starve_q, starve_d;

  always_comb begin
    promoted = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      promoted[i] = (starve_q[i] >= 8'(STARVE_LIMIT));
    end
  end

  always_comb begin
    starve_d = starve_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_vec[i]) begin
        starve_d[i] = '0;
      end else if (src_valid[i] && (starve_q[i] != 8'hFF)) begin
        starve_d[i] = starve_q[i] + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  always_comb begin
    promoted = '0;
  end
`endif

  always_comb begin
    load        = (state_q != HOLD) || ack_in;
    release_pkt = (state_q == HOLD) && ack_in && last_q;
    owner_only  = (state_q == LOCK) || ((state_q == HOLD) && !last_q);
    // A releasing owner hands the pointer on in the same cycle so back-to-back grants rotate.
    arb_ptr     = release_pkt ? wrap_add(owner_q, 1) : rr_ptr_q;
  end

  assign hi_cand = src_valid & (src_hipri | promoted);

  // Scanning from the far end lets the candidate nearest arb_ptr overwrite the rest.
  always_comb begin
    hi_pick  = arb_ptr;
    any_pick = arb_ptr;
    for (int unsigned k = NUM_REQ; k > 0; k--) begin
      if (hi_cand[wrap_add(arb_ptr, k - 1)]) begin
        hi_pick = wrap_add(arb_ptr, k - 1);
      end
      if (src_valid[wrap_add(arb_ptr, k - 1)]) begin
        any_pick = wrap_add(arb_ptr, k - 1);
      end
    end
  end

  always_comb begin
    grant     = 1'b0;
    grant_idx = owner_q;
    if (!rst && load) begin
      if (owner_only) begin
        grant = src_valid[owner_q];
      end else if (|src_valid) begin
        grant     = 1'b1;
        grant_idx = (|hi_cand) ? hi_pick : any_pick;
      end
    end
    grant_vec = '0;
    if (grant) begin
      grant_vec[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    flit_d   = flit_q;
    last_d   = last_q;
    owner_d  = owner_q;
    rr_ptr_d = release_pkt ? arb_ptr : rr_ptr_q;

    if ((state_q == HOLD) && ack_in) begin
      req_d = 1'b0;
    end

    case (state_q)
      IDLE: if (grant) state_d = HOLD;
      HOLD: if (ack_in) state_d = grant ? HOLD : (last_q ? IDLE : LOCK);
      LOCK: if (grant) state_d = HOLD;
      default: state_d = IDLE;
    endcase

    if (grant) begin
      req_d   = 1'b1;
      flit_d  = src_flit[grant_idx*FLIT_W +: FLIT_W];
      last_d  = src_last[grant_idx];
      owner_d = grant_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      flit_q   <= '0;
      last_q   <= 1'b0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      flit_q   <= flit_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign src_ready = grant_vec;
  assign req_out   = req_q;
  assign flit_out  = flit_q;
  assign owner     = owner_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_inject_arbiter.sv
// Self-checking bench for inject_arbiter: directed scenarios plus random traffic against a packet-level model.
module tb_inject_arbiter;

  localparam int N     = 4;
  localparam int W     = 64;
  localparam int LIMIT = 15;
  localparam int IW    = 2;
`ifdef INJECT_ARB_STARVE_EN
  localparam bit STARVE_EN = 1'b1;
`else
  localparam bit STARVE_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  src_valid;
  logic [N*W-1:0] src_flit;
  logic [N-1:0]  src_last;
  logic [N-1:0]  src_hipri;
  logic [N-1:0]  src_ready;
  logic          req_out;
  logic [W-1:0]  flit_out;
  logic          ack_in;
  logic [IW-1:0] owner;
  logic          busy;

  int checks = 0;
  int errors = 0;

  inject_arbiter #(.NUM_REQ(N), .FLIT_W(W), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst), .src_valid(src_valid), .src_flit(src_flit),
    .src_last(src_last), .src_hipri(src_hipri), .src_ready(src_ready),
    .req_out(req_out), .flit_out(flit_out), .ack_in(ack_in),
    .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  // Packet-level reference: output slot full?, packet owned?, owner, tail flag, pointer, wait counts.
  bit           m_full, m_pkt, m_last;
  int           m_owner, m_ptr;
  logic [W-1:0] m_flit;
  int           m_cnt [N];

  function automatic int model_pick();
    bit releasing;
    int ptr;
    int j;
    if (rst) return -1;
    if (m_full && !ack_in) return -1;
    releasing = m_full && m_last;
    if (m_pkt && !releasing) return src_valid[m_owner] ? m_owner : -1;
    ptr = releasing ? (m_owner + 1) % N : m_ptr;
    for (int k = 0; k < N; k++) begin
      j = (ptr + k) % N;
      if (src_valid[j] && (src_hipri[j] || (STARVE_EN && m_cnt[j] >= LIMIT))) return j;
    end
    for (int k = 0; k < N; k++) begin
      j = (ptr + k) % N;
      if (src_valid[j]) return j;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_full  <= 1'b0;
      m_pkt   <= 1'b0;
      m_last  <= 1'b0;
      m_owner <= 0;
      m_ptr   <= 0;
      m_flit  <= '0;
      for (int i = 0; i < N; i++) m_cnt[i] <= 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (model_pick() == i) m_cnt[i] <= 0;
        else if (src_valid[i] && m_cnt[i] < 255) m_cnt[i] <= m_cnt[i] + 1;
      end
      if (m_full && ack_in) begin
        m_full <= 1'b0;
        if (m_last) begin
          m_pkt <= 1'b0;
          m_ptr <= (m_owner + 1) % N;
        end
      end
      if (model_pick() >= 0) begin
        m_full  <= 1'b1;
        m_pkt   <= 1'b1;
        m_owner <= model_pick();
        m_last  <= src_last[model_pick()];
        m_flit  <= src_flit[model_pick()*W +: W];
      end
    end
  end

  function automatic logic [W-1:0] flit_pat(input int i, input int n);
    return {16'hC0DE, 16'(i), 32'(n)};
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic set_flit(input int i, input logic [W-1:0] v);
    src_flit[i*W +: W] = v;
  endtask

  task automatic do_reset();
    rst = 1'b1; src_valid = '0; src_last = '0; src_hipri = '0; ack_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; src_valid = '1; ack_in = 1'b0;
    #1;
    checks++; if (src_ready !== '0) begin errors++; $display("FAIL reset_ready got %b exp 0000", src_ready); end
    @(negedge clk);
    src_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (req_out !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", req_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (src_ready !== '0) begin errors++; $display("FAIL idle_ready got %b exp 0000", src_ready); end
    checks++; if (flit_out !== '0) begin errors++; $display("FAIL reset_flit got %h exp 0", flit_out); end
    checks++; if (owner !== '0) begin errors++; $display("FAIL reset_owner got %0d exp 0", owner); end
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    int order [5];
    order = '{0, 1, 2, 3, 0};
    do_reset();
    src_valid = '1; src_last = '1; src_hipri = '0; ack_in = 1'b1;
    for (int i = 0; i < N; i++) set_flit(i, flit_pat(i, 100));
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (src_ready !== onehot(order[k])) begin
        errors++; $display("FAIL rr_grant%0d got %b exp %b", k, src_ready, onehot(order[k]));
      end
      if (k > 0) begin
        checks++;
        if (flit_out !== flit_pat(order[k-1], 100) || req_out !== 1'b1) begin
          errors++; $display("FAIL rr_flit%0d got %h req %b exp %h", k, flit_out, req_out, flit_pat(order[k-1], 100));
        end
      end
      @(negedge clk);
    end
    src_valid = '0;
    @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0 || req_out !== 1'b0) begin errors++; $display("FAIL rr_drain got busy %b req %b exp 0 0", busy, req_out); end
    @(negedge clk);
  endtask

  task automatic test_wormhole();
    do_reset();
    ack_in = 1'b1; src_hipri = '0; src_valid = 4'b0011; src_last = 4'b0010;
    set_flit(1, flit_pat(1, 0));
    for (int f = 0; f < 3; f++) begin
      set_flit(0, flit_pat(0, f));
      src_last[0] = (f == 2);
      #1;
      checks++; if (src_ready !== 4'b0001) begin errors++; $display("FAIL worm_ready%0d got %b exp 0001", f, src_ready); end
      if (f > 0) begin
        checks++; if (flit_out !== flit_pat(0, f - 1)) begin errors++; $display("FAIL worm_flit%0d got %h exp %h", f, flit_out, flit_pat(0, f - 1)); end
      end
      @(negedge clk);
    end
    src_last[0] = 1'b0;
    #1;
    checks++; if (src_ready !== 4'b0010) begin errors++; $display("FAIL worm_next got %b exp 0010", src_ready); end
    checks++; if (flit_out !== flit_pat(0, 2)) begin errors++; $display("FAIL worm_tail got %h exp %h", flit_out, flit_pat(0, 2)); end
    @(negedge clk);
    src_valid = '0;
    #1;
    checks++; if (flit_out !== flit_pat(1, 0) || owner !== 2'd1) begin errors++; $display("FAIL worm_req1 got %h owner %0d exp %h owner 1", flit_out, owner, flit_pat(1, 0)); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int pulses;
    pulses = 0;
    do_reset();
    src_valid = 4'b1000; src_last = '1; src_hipri = '0; ack_in = 1'b0;
    set_flit(3, flit_pat(3, 7));
    #1;
    pulses += int'(src_ready[3]);
    checks++; if (src_ready !== 4'b1000) begin errors++; $display("FAIL bp_grant got %b exp 1000", src_ready); end
    @(negedge clk);
    set_flit(3, flit_pat(3, 8));
    for (int c = 0; c < 5; c++) begin
      #1;
      pulses += int'(src_ready[3]);
      checks++;
      if (req_out !== 1'b1 || flit_out !== flit_pat(3, 7) || src_ready !== '0) begin
        errors++; $display("FAIL bp_hold%0d got req %b flit %h rdy %b exp 1 %h 0000", c, req_out, flit_out, src_ready, flit_pat(3, 7));
      end
      @(negedge clk);
    end
    ack_in = 1'b1; src_valid = '0;
    #1;
    checks++; if (pulses !== 1) begin errors++; $display("FAIL bp_pulses got %0d exp 1", pulses); end
    @(negedge clk);
    #1;
    checks++; if (req_out !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_release got req %b busy %b exp 0 0", req_out, busy); end
    @(negedge clk);
  endtask

  task automatic test_starvation();
    int first;
    int n1;
    first = -1; n1 = 0;
    do_reset();
    src_valid = 4'b0110; src_hipri = 4'b0100; src_last = '1; ack_in = 1'b1;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (src_ready[1]) begin
        n1++;
        if (first < 0) first = c;
      end
      @(negedge clk);
    end
`ifdef INJECT_ARB_STARVE_EN
    checks++; if (first != LIMIT) begin errors++; $display("FAIL starve_first got %0d exp %0d", first, LIMIT); end
`else
    checks++; if (n1 != 0) begin errors++; $display("FAIL starve_none got %0d exp 0", n1); end
`endif
    src_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    do_reset();
    src_hipri = '0; ack_in = 1'b1; src_valid = 4'b0011; src_last = '0;
    set_flit(0, flit_pat(0, 1)); set_flit(1, flit_pat(1, 1)); set_flit(3, flit_pat(3, 1));
    #1;
    checks++; if (src_ready !== 4'b0001) begin errors++; $display("FAIL mid_grant got %b exp 0001", src_ready); end
    @(negedge clk);
    src_valid = 4'b0010;
    #1;
    checks++; if (src_ready !== '0) begin errors++; $display("FAIL mid_block got %b exp 0000", src_ready); end
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (busy !== 1'b1 || req_out !== 1'b0 || src_ready !== '0) begin
        errors++; $display("FAIL mid_lock%0d got busy %b req %b rdy %b exp 1 0 0000", c, busy, req_out, src_ready);
      end
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    checks++; if (src_ready !== '0) begin errors++; $display("FAIL mid_rst_ready got %b exp 0000", src_ready); end
    @(negedge clk);
    rst = 1'b0; src_valid = 4'b1000; src_last = 4'b1000;
    #1;
    checks++;
    if (req_out !== 1'b0 || busy !== 1'b0 || src_ready !== 4'b1000) begin
      errors++; $display("FAIL mid_after got req %b busy %b rdy %b exp 0 0 1000", req_out, busy, src_ready);
    end
    @(negedge clk);
    src_valid = '0;
    #1;
    checks++; if (owner !== 2'd3 || flit_out !== flit_pat(3, 1)) begin errors++; $display("FAIL mid_owner got %0d %h exp 3 %h", owner, flit_out, flit_pat(3, 1)); end
    @(negedge clk);
  endtask

  task automatic test_random(input int cycles);
    int p;
    logic [N-1:0] er;
    do_reset();
    for (int c = 0; c < cycles; c++) begin
      rst       = ($urandom_range(0, 199) == 0);
      src_valid = N'($urandom);
      for (int i = 0; i < N; i++) begin
        src_hipri[i] = ($urandom_range(0, 3) == 0);
        src_last[i]  = ($urandom_range(0, 2) == 0);
        set_flit(i, {$urandom, $urandom});
      end
      ack_in = ($urandom_range(0, 9) < 7);
      #1;
      p = model_pick();
      er = '0;
      if (p >= 0) er[p] = 1'b1;
      checks++; if (src_ready !== er) begin errors++; $display("FAIL rand_ready c%0d got %b exp %b", c, src_ready, er); end
      checks++; if (req_out !== m_full) begin errors++; $display("FAIL rand_req c%0d got %b exp %b", c, req_out, m_full); end
      checks++; if (flit_out !== m_flit) begin errors++; $display("FAIL rand_flit c%0d got %h exp %h", c, flit_out, m_flit); end
      checks++; if (owner !== IW'(m_owner)) begin errors++; $display("FAIL rand_owner c%0d got %0d exp %0d", c, owner, m_owner); end
      checks++; if (busy !== m_pkt) begin errors++; $display("FAIL rand_busy c%0d got %b exp %b", c, busy, m_pkt); end
      @(negedge clk);
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; src_valid = '0; src_flit = '0; src_last = '0; src_hipri = '0; ack_in = 1'b0;
    @(negedge clk);
    test_reset();
    test_round_robin();
    test_wormhole();
    test_backpressure();
    test_starvation();
    test_reset_mid();
    test_random(3000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
